// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to build the BUSY watchdog (o_timeout); otherwise o_timeout is tied low.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [NUM_REQ-1:0]   o_done,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || GAP_CYCLES > 65535 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, START, BUSY, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               start_q, start_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic [15:0]        gap_q, gap_d;

  logic [7:0]         req_ext;
  logic [63:0]        data_flat;
  logic [3:0]         sum4;
  logic [2:0]         win_idx;
  logic               win_vld;
  logic [2:0]         owner_nxt;
  logic               term;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
    logic [7:0] v;
    v = 8'd1 << idx;
    return v[NUM_REQ-1:0];
  endfunction

  // Zero-extend to the 8-requester maximum so 3-bit indices select exactly.
  assign req_ext   = 8'(i_req);
  assign data_flat = 64'(i_data);
  assign owner_nxt = (owner_q == 3'(NUM_REQ - 1)) ? 3'd0 : owner_q + 3'd1;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        to_q, to_d;
  assign term      = ((wd_q + 32'd1) == 32'(TIMEOUT_CYCLES));
  assign o_timeout = to_q;
`else
  assign term      = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Walk offsets from high to low so the lowest offset from ptr is the last writer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum4    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum4 = {1'b0, ptr_q} + 4'(i);
      if (sum4 >= 4'(NUM_REQ)) sum4 = sum4 - 4'(NUM_REQ);
      if (req_ext[sum4[2:0]]) begin
        win_vld = 1'b1;
        win_idx = sum4[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    data_d  = data_q;
    gap_d   = gap_q;
`ifdef UART_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          data_d  = data_flat[{win_idx, 3'b000} +: 8];
          gnt_d   = onehot(win_idx);
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
`ifdef UART_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = BUSY;
      end
      BUSY: begin
        // Completion takes precedence over a coincident watchdog terminal count.
        if (i_tx_done) begin
          done_d  = onehot(owner_q);
          ptr_d   = owner_nxt;
          gap_d   = '0;
          state_d = RELEASE;
        end else if (term) begin
`ifdef UART_ARB_TIMEOUT_EN
          to_d    = 1'b1;
`endif
          ptr_d   = owner_nxt;
          gap_d   = '0;
          state_d = RELEASE;
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
          wd_d    = wd_q + 32'd1;
`endif
        end
      end
      RELEASE: begin
        // The gap only starts counting once the transmitter drops done.
        if (i_tx_done) begin
          gap_d = '0;
        end else if (gap_q == 16'(GAP_CYCLES)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      gap_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      gap_q   <= gap_d;
`ifdef UART_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign o_gnt      = gnt_q;
  assign o_done     = done_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_busy     = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_txd` byte transmitter between `NUM_REQ` requesters. It sits between the requesting blocks and the transmitter. It accepts one byte at a time, issues a single-cycle start pulse with stable data, and waits for the transmitter's done indication. It then reports completion to the owning requester and rotates priority.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 2: idle clk cycles enforced between the end of one frame and the next start pulse; 0 is allowed.
- `TIMEOUT_CYCLES`, 200000: BUSY watchdog limit in clk cycles. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk` input 1: system clock; the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `i_req` input `NUM_REQ`: per-requester level request. Held until the matching `o_gnt`.
- `i_data` input `8*NUM_REQ`: requester k byte is on `i_data[8k+7:8k]`.
- `o_gnt` output `NUM_REQ`: one-hot, 1-cycle pulse when the byte is accepted.
- `o_done` output `NUM_REQ`: one-hot, 1-cycle pulse when that requester's frame has completed.
- `o_tx_start` output 1: 1-cycle start pulse to the transmitter.
- `o_tx_data` output 8: byte to the transmitter. Stable from the start pulse until leaving BUSY.
- `i_tx_done` input 1: transmitter done. Treated as a level that may stay high for several cycles.
- `o_busy` output 1: high in every state except IDLE.
- `o_timeout` output 1: 1-cycle pulse on watchdog abort.

## Operation
- States: IDLE, START, BUSY, RELEASE.
- IDLE:
  - If `i_req` is nonzero, select the winner: the first set bit at or above `ptr`, searching upward with wrap to 0.
  - Latch the winner's index into `owner` and its byte into `o_tx_data`.
  - Move to START.
- START (exactly 1 cycle):
  - `o_tx_start`=1 and `o_gnt[owner]`=1.
  - Move to BUSY.
- BUSY:
  - Hold `o_tx_data`.
  - When `i_tx_done` is 1: pulse `o_done[owner]` on the next cycle, set `ptr` = (`owner`+1) mod `NUM_REQ`, and move to RELEASE.
- RELEASE:
  - Wait until `i_tx_done` is 0.
  - Then count `GAP_CYCLES` cycles and go to IDLE.
  - With `GAP_CYCLES`=0, go to IDLE on the first cycle with `i_tx_done` low.
- `ptr` resets to 0 and is 3 bits wide (enough for up to 8 requesters); it wraps modulo `NUM_REQ`.
- Changes to `i_req` outside IDLE are ignored. A requester dropping `i_req` before its grant simply loses that arbitration.
- `i_tx_done` asserted outside BUSY is ignored.
- Requests that arrive during START, BUSY or RELEASE wait; they are arbitrated in the first IDLE cycle.

## Timing
- Reset values:
  - State IDLE, `ptr`=0, `owner`=0.
  - `o_gnt`=0, `o_done`=0, `o_tx_start`=0, `o_tx_data`=8'h00, `o_busy`=0, `o_timeout`=0.
- Reset asserted mid-frame: all of the above return immediately (asynchronously). No `o_done` is issued for the interrupted byte.
- Request latency:
  - `i_req` sampled high in IDLE at edge T gives `o_tx_start`/`o_gnt` high in cycle T+1.
  - BUSY is entered at T+2.
- Done latency: `i_tx_done` sampled high in BUSY at edge D gives `o_done` high in cycle D+1. `o_done` and `o_timeout` are never high together.
- Minimum spacing between two `o_tx_start` pulses is 4 + `GAP_CYCLES` cycles, when `i_tx_done` is a 1-cycle pulse.
- All outputs are registered.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A 32-bit counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES` with `i_tx_done` still low: pulse `o_timeout`, suppress `o_done`, advance `ptr` as for completion, and move to RELEASE.
  - If `i_tx_done` and the terminal count coincide, completion wins.
- Not defined:
  - No counter is built; `o_timeout` is tied to 0.
  - BUSY waits indefinitely for `i_tx_done`.

## Test plan
- Single request: `i_req`=4'b0010, `i_data[15:8]`=8'hA5.
  - Expected: `o_tx_start` and `o_gnt`=4'b0010 one cycle later; `o_tx_data`=8'hA5.
  - After a `i_tx_done` pulse: `o_done`=4'b0010 one cycle later; `o_busy` low after RELEASE plus 2 gap cycles.
- Round-robin: `i_req`=4'b1111 held, with done pulses returned after each start.
  - Expected: grant order 0,1,2,3,0.
  - Each grant is separated by at least 6 cycles; data matches each requester's lane.
- Wrap and skip: `ptr`=3 after serving requester 2, then `i_req`=4'b0101.
  - Expected: grant goes to requester 0, then requester 2.
- Long done level: hold `i_tx_done` high for 5 cycles.
  - Expected: exactly one `o_done` pulse.
  - No new start pulse until `i_tx_done` is low plus `GAP_CYCLES`.
- Reset mid-BUSY: assert `rst` 10 cycles after start.
  - Expected: all outputs at reset values at once.
  - After release, `i_req`=4'b1000 is granted to requester 3; `ptr` restarts from 0.
- Timeout (with `UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=50): no `i_tx_done`.
  - Expected: `o_timeout` pulse after 50 BUSY cycles and no `o_done`.
  - The next pending requester is granted after RELEASE.
